// File: rtl/uart_axis_pkg.sv
// uart_axis_pkg: shared entry and state types for the UART AXI-Stream framer
package uart_axis_pkg;
  typedef struct packed {
    logic       tlast;
    logic       tuser;
    logic [7:0] tdata;
  } uart_axis_entry_t;
  typedef enum logic [0:0] {EMPTY, HELD} framer_state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module axis_sync_fifo
  import uart_axis_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = uart_axis_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  T                         i_din,
  input  logic                     i_pop,
  output T                         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wr, r_rd;
  T            r_mem [DEPTH];
  logic        w_wr, w_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = r_wr == r_rd;
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;
  assign o_level = r_wr - r_rd;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr && !i_clear) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/uart_rx_axis_framer.sv
// uart_rx_axis_framer: buffers UART bytes and closes idle-delimited packets with tlast
module uart_rx_axis_framer
  import uart_axis_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 17360,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [7:0]                    s_tdata,
  input  logic                          s_tuser,
  input  logic                          s_tvalid,
  output logic [7:0]                    m_tdata,
  output logic                          m_tuser,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic                          clear,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  framer_state_t    r_state, w_next;
  logic [8:0]       r_hold;
  logic [CW-1:0]    r_idle;
  uart_axis_entry_t w_push_entry, w_head;
  logic             w_push, w_pop, w_full, w_empty, w_drop, w_timeout;
  assign w_timeout = r_idle == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_state <= EMPTY;
    else if (clear) r_state <= EMPTY;
    else r_state <= w_next;
  always_comb
    w_next = s_tvalid ? HELD : (r_state == HELD && w_timeout) ? EMPTY : r_state;
  // A new arrival always wins over a coincident timeout, so the held byte is not closed
  always_comb begin
    w_push       = (r_state == HELD) && (s_tvalid || w_timeout);
    w_push_entry = {!s_tvalid, r_hold};
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_hold <= '0;
      r_idle <= '0;
    end else if (clear) begin
      r_hold <= '0;
      r_idle <= '0;
    end else if (s_tvalid) begin
      r_hold <= {s_tuser, s_tdata};
      r_idle <= '0;
    end else if (r_state == HELD) begin
      r_idle <= w_timeout ? '0 : r_idle + 1'b1;
    end
  assign w_pop  = m_tvalid && m_tready;
  assign w_drop = w_push && w_full && !w_pop;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (w_drop) begin
      overflow   <= 1'b1;
      drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
    end
  axis_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(uart_axis_entry_t)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .i_clear (clear),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );
  assign m_tvalid = !w_empty;
  assign m_tdata  = w_head.tdata;
  assign m_tuser  = w_head.tuser;
  assign m_tlast  = w_head.tlast;
endmodule

// File: tb/tb_uart_rx_axis_framer.sv
// tb_uart_rx_axis_framer: directed checks of framing, timeout boundary, overflow, reset and clear
module tb_uart_rx_axis_framer;
  localparam int D = 4;
  localparam int T = 32;
  logic       aclk = 0, areset = 1, clear = 0;
  logic [7:0] s_tdata = 0;
  logic       s_tuser = 0, s_tvalid = 0, m_tready = 0;
  logic [7:0] m_tdata;
  logic       m_tuser, m_tlast, m_tvalid, overflow;
  logic [15:0] drop_count;
  logic [2:0]  fifo_level;
  logic [9:0]  q[$];
  int n_checks = 0, n_fail = 0;
  uart_rx_axis_framer #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .DROP_CNT_W(16)) dut (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .clear(clear), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk)
    if (!areset && !clear && m_tvalid && m_tready) q.push_back({m_tlast, m_tuser, m_tdata});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] qat(input int i);
    return (i < q.size()) ? q[i] : 10'h3ff;
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic u);
    s_tdata = d; s_tuser = u; s_tvalid = 1;
    idle(1);
    s_tvalid = 0; s_tuser = 0;
  endtask
  task automatic flush;
    clear = 1;
    idle(1);
    clear = 0;
    q.delete();
  endtask
  initial begin
    idle(2);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", {m_tlast, m_tuser, m_tdata}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", {overflow, drop_count}, 0);
    areset = 0;
    idle(1);
    // 1: three-byte packet closed by idle time
    m_tready = 1;
    send(8'h41, 0); idle(9);
    send(8'h42, 0); idle(9);
    send(8'h43, 0); idle(T + 5);
    chk("t1_n", q.size(), 3);
    chk("t1_b0", qat(0), 10'h041);
    chk("t1_b1", qat(1), 10'h042);
    chk("t1_b2", qat(2), 10'h243);
    // 2: single byte with parity error, exact latency
    q.delete(); m_tready = 0;
    send(8'h55, 1); idle(T - 1);
    chk("t2_early", m_tvalid, 0);
    idle(1);
    chk("t2_valid", m_tvalid, 1);
    chk("t2_entry", {m_tlast, m_tuser, m_tdata}, 10'h355);
    m_tready = 1; idle(2);
    chk("t2_drained", fifo_level, 0);
    // 3: overflow with the consumer stalled
    flush(); m_tready = 0;
    for (int i = 0; i < D + 3; i++) send(8'h10 + 8'(i), 0);
    chk("t3_level", fifo_level, D);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 2);
    idle(T);
    chk("t3_drop_to", drop_count, 3);
    m_tready = 1; idle(8);
    chk("t3_n", q.size(), D);
    for (int i = 0; i < D; i++) chk($sformatf("t3_b%0d", i), qat(i), 10'h010 + 10'(i));
    // 4: arrival coincides with the timeout edge
    flush(); m_tready = 1;
    send(8'h61, 0); idle(T - 1);
    send(8'h62, 0); idle(T + 3);
    chk("t4_n", q.size(), 2);
    chk("t4_b0", qat(0), 10'h061);
    chk("t4_b1", qat(1), 10'h262);
    // 5: push into a full FIFO while popping
    flush(); m_tready = 0;
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 0);
    chk("t5_full", fifo_level, D);
    m_tready = 1; send(8'h75, 0); m_tready = 0;
    chk("t5_level", fifo_level, D);
    chk("t5_ovf", {overflow, drop_count}, 0);
    m_tready = 1; idle(T + 8);
    chk("t5_n", q.size(), 6);
    chk("t5_b0", qat(0), 10'h070);
    chk("t5_b4", qat(4), 10'h074);
    chk("t5_b5", qat(5), 10'h275);
    // 6: async reset then sync clear mid-packet
    flush(); m_tready = 0;
    for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 0);
    chk("t6_pre_ovf", overflow, 1);
    areset = 1; #2;
    chk("t6_rst_valid", m_tvalid, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_ovf", {overflow, drop_count}, 0);
    areset = 0; idle(1);
    q.delete(); m_tready = 1; idle(T + 3);
    chk("t6_no_tlast", q.size(), 0);
    m_tready = 0;
    for (int i = 0; i < 6; i++) send(8'h90 + 8'(i), 0);
    flush();
    chk("t6_clr_valid", m_tvalid, 0);
    chk("t6_clr_level", fifo_level, 0);
    chk("t6_clr_ovf", {overflow, drop_count}, 0);
    m_tready = 1;
    send(8'h99, 0); idle(T + 3);
    chk("t6_n", q.size(), 1);
    chk("t6_b0", qat(0), 10'h299);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
